// File: rtl/counter_multimode_if.sv
// Control/status bundle for counter_multimode: the master drives the controls,
// the slave (the counter) drives count and the status flags.
interface counter_multimode_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             start;
  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;
  logic             dir_o;

  modport master (
    output clr, start, en, dir, mode, limit,
    input  count, busy, done, tc, dir_o
  );

  modport slave (
    input  clr, start, en, dir, mode, limit,
    output count, busy, done, tc, dir_o
  );
endinterface

// File: rtl/counter_multimode.sv
// Up/down counter with one-shot, wrap, ping-pong and free-run modes, a terminal-count
// pulse and an IDLE/RUN/DONE run-state FSM.
module counter_multimode #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_multimode_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_WRAP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_FREE     = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic [1:0]       mode_reg, mode_next;
  logic             dir_reg, dir_next;
  logic             tc_reg, tc_next;

  logic             free_run;
  logic             step;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] result;
  logic             hit;

  // State register plus the datapath registers it qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= ZERO;
      limit_reg <= ZERO;
      mode_reg  <= 2'b00;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      limit_reg <= limit_next;
      mode_reg  <= mode_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
    end
  end

  // A zero limit degrades every mode to a plain modulo-2^WIDTH counter.
  always_comb begin
    free_run = (mode_reg == MODE_FREE) || (limit_reg == ZERO);
    step     = (state_reg == RUN) && bus.en;

    if (dir_reg)
      term = ZERO;
    else
      term = free_run ? ALL_ONES : limit_reg;

    result = dir_reg ? (count_reg - 1'b1) : (count_reg + 1'b1);
    if (!free_run && (mode_reg == MODE_WRAP) && (count_reg == term))
      result = dir_reg ? limit_reg : ZERO;

    hit = (result == term);
  end

  // Datapath next values; clr beats start, start beats a step.
  always_comb begin
    count_next = count_reg;
    limit_next = limit_reg;
    mode_next  = mode_reg;
    dir_next   = dir_reg;
    tc_next    = 1'b0;

    if (bus.clr) begin
      count_next = ZERO;
      dir_next   = 1'b0;
    end else if (bus.start) begin
      limit_next = bus.limit;
      mode_next  = bus.mode;
      dir_next   = bus.dir;
      if (!bus.dir)
        count_next = ZERO;
      else if ((bus.mode == MODE_FREE) || (bus.limit == ZERO))
        count_next = ALL_ONES;
      else
        count_next = bus.limit;
    end else if (step) begin
      count_next = result;
      tc_next    = hit;
      if (!free_run && (mode_reg == MODE_PINGPONG) && hit)
        dir_next = ~dir_reg;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (bus.clr)
      state_next = IDLE;
    else if (bus.start)
      state_next = RUN;
    else if (step && !free_run && (mode_reg == MODE_ONESHOT) && hit)
      state_next = DONE;
  end

  // Outputs, all sourced from registers.
  always_comb begin
    bus.count = count_reg;
    bus.tc    = tc_reg;
    bus.dir_o = dir_reg;
    bus.busy  = (state_reg == RUN);
    bus.done  = (state_reg == DONE);
  end

endmodule
